// File: rtl/vrf_resp_rx_pkg.sv
// vrf_resp_rx_pkg: frame geometry, UART rate and receiver state encoding shared with the TX controller
package vrf_resp_rx_pkg;
    localparam logic [15:0] CHAL_SIZE_WORDS = 16'h10;
    localparam logic [15:0] MAC_WORDS = 16'h10;
    localparam logic [15:0] METADATA_SIZE_WORDS = 16'h1;
    localparam int TX_RATE = 180;
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_ERR} rx_state_e;
endpackage

// File: rtl/vrf_resp_rx_word_pack.sv
// rx_word_pack: assembles low/high UART byte pairs into 16-bit words with a one-cycle write strobe
module rx_word_pack (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        lo_en,
    input  logic        hi_en,
    input  logic [7:0]  rx_byte,
    output logic [15:0] word,
    output logic        wr_en,
    output logic [15:0] wr_data
);
    logic [7:0] lo;
    assign word = {rx_byte, lo};
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            lo <= '0;
            wr_en <= 1'b0;
            wr_data <= '0;
        end else begin
            wr_en <= hi_en;
            if (lo_en) lo <= rx_byte;
            if (hi_en) wr_data <= word;
        end
    end
endmodule

// File: rtl/vrf_resp_rx.sv
// vrf_resp_rx: receives verifier response frames over UART into acfa memory; VRF_RESP_RX_TIMEOUT_EN adds an inter-byte timeout
module vrf_resp_rx #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] CHAL_SIZE_WORDS = vrf_resp_rx_pkg::CHAL_SIZE_WORDS,
    parameter logic [15:0] MAC_WORDS = vrf_resp_rx_pkg::MAC_WORDS
`ifdef VRF_RESP_RX_TIMEOUT_EN
    , parameter int RX_TIMEOUT = 4 * vrf_resp_rx_pkg::TX_RATE
`endif
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        resp_ack,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic [15:0] vrf_response_out,
    output logic        resp_valid,
    output logic        rx_busy,
    output logic        rx_error
);
    import vrf_resp_rx_pkg::*;
    localparam logic [15:0] FRAME_WORDS = METADATA_SIZE_WORDS + CHAL_SIZE_WORDS + MAC_WORDS;
    rx_state_e state;
    logic [15:0] word_idx, header, word, hdr_next;
    logic lo_en, hi_en, last;
`ifdef VRF_RESP_RX_TIMEOUT_EN
    logic [15:0] tmo_cnt;
`endif
    assign lo_en = rx_valid && (state == S_IDLE || state == S_LO);
    assign hi_en = rx_valid && state == S_HI;
    assign last = word_idx == FRAME_WORDS - 16'd1;
    // word 0 is the header; it is needed the same cycle it arrives if the frame is one word long
    assign hdr_next = word_idx == '0 ? word : header;
    assign rx_busy = state == S_LO || state == S_HI;
    rx_word_pack u_pack (
        .mclk(mclk),
        .puc_rst(puc_rst),
        .lo_en(lo_en),
        .hi_en(hi_en),
        .rx_byte(rx_byte),
        .word(word),
        .wr_en(wr_en),
        .wr_data(wr_data)
    );
    always_ff @(posedge mclk) begin
        resp_valid <= 1'b0;
        if (puc_rst) begin
            state <= S_IDLE;
            word_idx <= '0;
            header <= '0;
            wr_addr <= '0;
            vrf_response_out <= '0;
            rx_error <= 1'b0;
`ifdef VRF_RESP_RX_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            if (resp_ack) vrf_response_out <= '0;
            if (resp_ack && state == S_IDLE) rx_error <= 1'b0;
            if (lo_en) state <= S_HI;
            if (state == S_ERR) state <= S_IDLE;
            if (hi_en) begin
                wr_addr <= BASE_ADDR + word_idx;
                header <= hdr_next;
                word_idx <= last ? '0 : word_idx + 16'd1;
                state <= last ? S_IDLE : S_LO;
                if (last && hdr_next == '0) rx_error <= 1'b1;
                // completion beats a coincident ack; a still-pending response is an overrun
                if (last && hdr_next != '0) begin
                    vrf_response_out <= hdr_next;
                    resp_valid <= 1'b1;
                    if (vrf_response_out != '0) rx_error <= 1'b1;
                end
            end
`ifdef VRF_RESP_RX_TIMEOUT_EN
            tmo_cnt <= rx_valid || !rx_busy ? '0 : tmo_cnt + 16'd1;
            if (rx_busy && !rx_valid && tmo_cnt == 16'(RX_TIMEOUT - 1)) begin
                state <= S_ERR;
                word_idx <= '0;
                rx_error <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_vrf_resp_rx.sv
// tb_vrf_resp_rx: directed frames against a byte-position model of the response receiver
module tb_vrf_resp_rx;
    localparam logic [15:0] BASE = 16'hFFF0;
    localparam int FW = 33;
    localparam int TMO = 720;
    logic mclk = 1'b0;
    logic puc_rst = 1'b1, rx_valid = 1'b0, resp_ack = 1'b0;
    logic [7:0] rx_byte = '0;
    logic wr_en, resp_valid, rx_busy, rx_error;
    logic [15:0] wr_addr, wr_data, vrf_response_out;
    int checks = 0, errors = 0;
    int n_wr = 0, n_rv = 0;
    logic [15:0] last_addr = '0;
    bit run = 0;
    logic [15:0] m_resp = '0, m_hdr = '0, m_wr_addr = '0, m_wr_data = '0, mw;
    logic [7:0] m_lo = '0;
    int m_pos = 0, m_idle = 0;
    bit m_err = 0, m_rv = 0, m_wr_en = 0, m_errwait = 0, m_good;

    vrf_resp_rx #(.BASE_ADDR(BASE)) dut (
        .mclk(mclk),
        .puc_rst(puc_rst),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .resp_ack(resp_ack),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .vrf_response_out(vrf_response_out),
        .resp_valid(resp_valid),
        .rx_busy(rx_busy),
        .rx_error(rx_error)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // frame model: m_pos counts bytes received in the current frame
    always @(posedge mclk) begin
        m_wr_en = 0;
        m_rv = 0;
        m_good = 0;
        if (puc_rst) begin
            m_pos = 0; m_hdr = '0; m_resp = '0; m_err = 0; m_errwait = 0; m_idle = 0;
        end else begin
            if (resp_ack && m_pos == 0 && !m_errwait) m_err = 0;
            if (m_errwait) m_errwait = 0;
            else if (rx_valid) begin
                m_idle = 0;
                if (m_pos % 2 == 0) m_lo = rx_byte;
                else begin
                    mw = {rx_byte, m_lo};
                    if (m_pos / 2 == 0) m_hdr = mw;
                    m_wr_en = 1;
                    m_wr_addr = BASE + 16'(m_pos / 2);
                    m_wr_data = mw;
                end
                m_pos++;
                if (m_pos == 2 * FW) begin
                    m_pos = 0;
                    if (m_hdr == '0) m_err = 1;
                    else begin
                        if (m_resp != '0) m_err = 1;
                        m_resp = m_hdr;
                        m_rv = 1;
                        m_good = 1;
                    end
                end
            end
`ifdef VRF_RESP_RX_TIMEOUT_EN
            else if (m_pos != 0) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_pos = 0; m_idle = 0; m_err = 1; m_errwait = 1;
                end
            end
`endif
            if (resp_ack && !m_good) m_resp = '0;
        end
    end

    always @(negedge mclk) if (run) begin
        chk("wr_en", wr_en, m_wr_en);
        chk("resp_valid", resp_valid, m_rv);
        chk("vrf_response_out", vrf_response_out, m_resp);
        chk("rx_busy", rx_busy, m_pos != 0);
        chk("rx_error", rx_error, m_err);
        if (m_wr_en) begin
            chk("wr_addr", wr_addr, m_wr_addr);
            chk("wr_data", wr_data, m_wr_data);
        end
        if (wr_en) begin
            n_wr++;
            last_addr = wr_addr;
        end
        if (resp_valid) n_rv++;
    end

    task automatic drive(input logic [7:0] b);
        @(negedge mclk);
        rx_valid = 1'b1;
        rx_byte = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge mclk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_part(input logic [15:0] hdr, input int from, input int to);
        logic [15:0] w;
        for (int i = from; i <= to; i++) begin
            w = i == 0 ? hdr : 16'(i);
            drive(w[7:0]);
            drive(w[15:8]);
        end
    endtask

    task automatic ack();
        @(negedge mclk);
        rx_valid = 1'b0;
        resp_ack = 1'b1;
        @(negedge mclk);
        resp_ack = 1'b0;
    endtask

    initial begin
        int w0, r0;
        repeat (2) @(negedge mclk);
        run = 1;
        chk("rst wr_en", wr_en, 16'h0);
        chk("rst wr_addr", wr_addr, 16'h0);
        chk("rst wr_data", wr_data, 16'h0);
        chk("rst vrf_response_out", vrf_response_out, 16'h0);
        chk("rst rx_error", rx_error, 16'h0);
        puc_rst = 1'b0;
        // good frame, addresses wrap past 16'hFFFF
        send_part(16'hA5A5, 0, FW - 1);
        idle(3);
        chk("f1 writes", 16'(n_wr), 16'd33);
        chk("f1 resp_valid pulses", 16'(n_rv), 16'd1);
        chk("f1 response", vrf_response_out, 16'hA5A5);
        chk("f1 last addr", last_addr, 16'h0010);
        ack();
        chk("ack clears response", vrf_response_out, 16'h0000);
        send_part(16'h0003, 0, FW - 1);
        idle(3);
        chk("f2 response", vrf_response_out, 16'h0003);
        chk("f2 rx_error", rx_error, 16'h0);
        // zero header: written but rejected
        w0 = n_wr; r0 = n_rv;
        send_part(16'h0000, 0, FW - 1);
        idle(3);
        chk("zero hdr writes", 16'(n_wr - w0), 16'd33);
        chk("zero hdr resp_valid", 16'(n_rv - r0), 16'd0);
        chk("zero hdr rx_error", rx_error, 16'h1);
        chk("zero hdr response kept", vrf_response_out, 16'h0003);
        ack();
        chk("ack clears rx_error", rx_error, 16'h0);
        // stall mid-frame for longer than the timeout
        send_part(16'h1234, 0, 4);
        idle(TMO + 1);
`ifdef VRF_RESP_RX_TIMEOUT_EN
        chk("timeout rx_error", rx_error, 16'h1);
        chk("timeout rx_busy", rx_busy, 16'h0);
        send_part(16'h1234, 0, FW - 1);
`else
        chk("stall rx_busy", rx_busy, 16'h1);
        chk("stall rx_error", rx_error, 16'h0);
        send_part(16'h1234, 5, FW - 1);
`endif
        idle(3);
        chk("after stall response", vrf_response_out, 16'h1234);
        ack();
        // reset after byte 7
        send_part(16'hBEEF, 0, 2);
        drive(8'h03);
        @(negedge mclk);
        rx_valid = 1'b0;
        puc_rst = 1'b1;
        @(negedge mclk);
        puc_rst = 1'b0;
        chk("mid rst wr_en", wr_en, 16'h0);
        chk("mid rst wr_addr", wr_addr, 16'h0);
        chk("mid rst wr_data", wr_data, 16'h0);
        chk("mid rst rx_busy", rx_busy, 16'h0);
        chk("mid rst response", vrf_response_out, 16'h0);
        send_part(16'h0042, 0, FW - 1);
        idle(3);
        chk("post rst response", vrf_response_out, 16'h0042);
        chk("post rst rx_error", rx_error, 16'h0);
        ack();
        // back-to-back frames, second starts in the first's completion cycle
        w0 = n_wr; r0 = n_rv;
        send_part(16'h0011, 0, FW - 1);
        send_part(16'h0022, 0, FW - 1);
        idle(3);
        chk("b2b writes", 16'(n_wr - w0), 16'd66);
        chk("b2b resp_valid", 16'(n_rv - r0), 16'd2);
        chk("b2b response", vrf_response_out, 16'h0022);
        chk("b2b overrun", rx_error, 16'h1);
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
